// File: rtl/mem_req_arbiter.sv
// Arbiter for the shared line-memory port: VC-priority grant with an L1 starvation guard,
// a grant held for the whole transaction, owner-routed responses and a per-transaction timeout.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_BYTES       = 16,
  parameter int VICTIM_TAG_WIDTH = 27,
  parameter int MAX_VC_STREAK    = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        l1_req_valid,
  input  logic                        l1_req_rw,
  input  logic [ADDR_WIDTH-1:0]       l1_req_addr,
  input  logic [LINE_BYTES*8-1:0]     l1_req_wdata,
  output logic                        l1_resp_valid,
  output logic [LINE_BYTES*8-1:0]     l1_resp_rdata,
  input  logic                        vc_req_valid,
  input  logic                        vc_req_write,
  input  logic [VICTIM_TAG_WIDTH-1:0] vc_req_tag,
  input  logic [LINE_BYTES*8-1:0]     vc_req_wdata,
  output logic                        vc_resp_valid,
  output logic                        mem_req_valid,
  output logic                        mem_req_rw,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [LINE_BYTES*8-1:0]     mem_req_wdata,
  input  logic                        mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0]     mem_resp_rdata,
  output logic                        owner,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int OFFSET       = $clog2(LINE_BYTES);
  localparam int DATA_WIDTH   = LINE_BYTES * 8;
  localparam int VC_ADDR_BITS = VICTIM_TAG_WIDTH + OFFSET;
  localparam int STREAK_W     = $clog2(MAX_VC_STREAK + 1);
  localparam int TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic                    owner_reg;
  logic                    rw_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STREAK_W-1:0]     streak_reg;
  logic [TIMER_W-1:0]      timer_reg;
  logic                    timeout_err_reg;

  logic                    streak_full;
  logic                    grant_vc;
  logic                    grant_l1;
  logic                    grant_any;
  logic                    in_busy;
  logic                    timeout_hit;
  logic                    txn_done;
  logic [VC_ADDR_BITS-1:0] vc_line_addr;
  logic [ADDR_WIDTH-1:0]   vc_addr;

  // Arbitration: VC wins unless L1 is waiting and VC has used up its streak.
  assign streak_full  = (streak_reg == STREAK_W'(MAX_VC_STREAK));
  assign grant_vc     = vc_req_valid && !(l1_req_valid && streak_full);
  assign grant_l1     = l1_req_valid && !grant_vc;
  assign grant_any    = grant_vc || grant_l1;

  assign vc_line_addr = VC_ADDR_BITS'(vc_req_tag) << OFFSET;
  assign vc_addr      = ADDR_WIDTH'(vc_line_addr);

  // A real response in the timeout cycle takes precedence over the timeout.
  assign in_busy      = (state_reg == BUSY);
  assign timeout_hit  = in_busy && !mem_resp_valid && (timer_reg == TIMER_W'(TIMEOUT_CYCLES));
  assign txn_done     = in_busy && (mem_resp_valid || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = BUSY;
      BUSY:    if (txn_done)  state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = in_busy;
    busy          = in_busy;
    mem_req_rw    = rw_reg;
    mem_req_addr  = addr_reg;
    mem_req_wdata = wdata_reg;
    owner         = owner_reg;
    timeout_err   = timeout_err_reg;
    l1_resp_valid = txn_done && !owner_reg;
    vc_resp_valid = txn_done && owner_reg;
    l1_resp_rdata = '0;
    if (l1_resp_valid && mem_resp_valid && !rw_reg) begin
      l1_resp_rdata = mem_resp_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg       <= 1'b0;
      rw_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      streak_reg      <= '0;
      timer_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && grant_any) begin
        owner_reg <= grant_vc;
        timer_reg <= '0;
        if (grant_vc) begin
          rw_reg    <= vc_req_write;
          addr_reg  <= vc_addr;
          wdata_reg <= vc_req_wdata;
          if (l1_req_valid && !streak_full) begin
            streak_reg <= streak_reg + STREAK_W'(1);
          end
        end else begin
          rw_reg     <= l1_req_rw;
          addr_reg   <= l1_req_addr;
          wdata_reg  <= l1_req_wdata;
          streak_reg <= '0;
        end
      end
      if (in_busy && !txn_done) begin
        timer_reg <= timer_reg + TIMER_W'(1);
      end
      if (timeout_hit) begin
        timeout_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter (MAX_VC_STREAK=4, TIMEOUT_CYCLES=8).
module tb_mem_req_arbiter;

  logic         clk;
  logic         rst_n;
  logic         l1_req_valid;
  logic         l1_req_rw;
  logic [31:0]  l1_req_addr;
  logic [127:0] l1_req_wdata;
  logic         l1_resp_valid;
  logic [127:0] l1_resp_rdata;
  logic         vc_req_valid;
  logic         vc_req_write;
  logic [26:0]  vc_req_tag;
  logic [127:0] vc_req_wdata;
  logic         vc_resp_valid;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rdata;
  logic         owner;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int passes = 0;

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] DATA_3C = {16{8'h3C}};
  localparam logic [127:0] WDATA_V = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
  localparam logic [127:0] WDATA_L = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  mem_req_arbiter #(
    .ADDR_WIDTH(32), .LINE_BYTES(16), .VICTIM_TAG_WIDTH(27),
    .MAX_VC_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .l1_req_valid(l1_req_valid), .l1_req_rw(l1_req_rw), .l1_req_addr(l1_req_addr),
    .l1_req_wdata(l1_req_wdata), .l1_resp_valid(l1_resp_valid), .l1_resp_rdata(l1_resp_rdata),
    .vc_req_valid(vc_req_valid), .vc_req_write(vc_req_write), .vc_req_tag(vc_req_tag),
    .vc_req_wdata(vc_req_wdata), .vc_resp_valid(vc_resp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l1_req_valid = 0; l1_req_rw = 0; l1_req_addr = '0; l1_req_wdata = '0;
    vc_req_valid = 0; vc_req_write = 0; vc_req_tag = '0; vc_req_wdata = '0;
    mem_resp_valid = 0; mem_resp_rdata = '0;
    tick(); tick();
    #2;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid got %b want 0", mem_req_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (owner !== 1'b0) $display("FAIL reset_owner got %b want 0", owner); else passes++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got %b want 0", timeout_err); else passes++;
    checks++; if ({l1_resp_valid, vc_resp_valid} !== 2'b00) $display("FAIL reset_resp got %b want 00", {l1_resp_valid, vc_resp_valid}); else passes++;
    checks++; if ({mem_req_rw, mem_req_addr} !== 33'd0) $display("FAIL reset_rw_addr got %h want 0", {mem_req_rw, mem_req_addr}); else passes++;
    checks++; if (mem_req_wdata !== 128'd0) $display("FAIL reset_wdata got %h want 0", mem_req_wdata); else passes++;
    tick();
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_l1_read();
    l1_req_valid = 1; l1_req_rw = 0; l1_req_addr = 32'h0000_1230; l1_req_wdata = WDATA_L;
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL l1rd_idle_busy got %b want 0", busy); else passes++;
    tick(); #2;
    checks++; if ({mem_req_valid, busy, owner, mem_req_rw} !== 4'b1100) $display("FAIL l1rd_issue v/b/o/rw got %b want 1100", {mem_req_valid, busy, owner, mem_req_rw}); else passes++;
    checks++; if (mem_req_addr !== 32'h0000_1230) $display("FAIL l1rd_addr got %h want 00001230", mem_req_addr); else passes++;
    tick(); #2;
    checks++; if (l1_resp_valid !== 1'b0) $display("FAIL l1rd_early_resp got %b want 0", l1_resp_valid); else passes++;
    tick();
    mem_resp_valid = 1; mem_resp_rdata = DATA_A5;
    #2;
    checks++; if ({l1_resp_valid, vc_resp_valid} !== 2'b10) $display("FAIL l1rd_resp l1/vc got %b want 10", {l1_resp_valid, vc_resp_valid}); else passes++;
    checks++; if (l1_resp_rdata !== DATA_A5) $display("FAIL l1rd_rdata got %h want %h", l1_resp_rdata, DATA_A5); else passes++;
    tick();
    mem_resp_valid = 0;
    #2;
    checks++; if ({busy, mem_req_valid, l1_resp_valid} !== 3'b000) $display("FAIL l1rd_drain b/v/resp got %b want 000", {busy, mem_req_valid, l1_resp_valid}); else passes++;
    checks++; if (l1_resp_rdata !== 128'd0) $display("FAIL l1rd_rdata_idle got %h want 0", l1_resp_rdata); else passes++;
    l1_req_valid = 0;
    tick(); #2;
    checks++; if (busy !== 1'b0) $display("FAIL l1rd_no_regrant got %b want 0", busy); else passes++;
    $display("l1_read: addr=%h rdata=%h", 32'h0000_1230, DATA_A5);
  endtask

  task automatic test_vc_priority();
    l1_req_valid = 1; l1_req_rw = 0; l1_req_addr = 32'h0000_2000;
    vc_req_valid = 1; vc_req_write = 1; vc_req_tag = 27'h0123456; vc_req_wdata = WDATA_V;
    tick(); #2;
    checks++; if ({owner, mem_req_rw} !== 2'b11) $display("FAIL vcpri_owner_rw got %b want 11", {owner, mem_req_rw}); else passes++;
    checks++; if (mem_req_addr !== 32'h0123_4560) $display("FAIL vcpri_addr got %h want 01234560", mem_req_addr); else passes++;
    checks++; if (mem_req_wdata !== WDATA_V) $display("FAIL vcpri_wdata got %h want %h", mem_req_wdata, WDATA_V); else passes++;
    tick();
    mem_resp_valid = 1; mem_resp_rdata = DATA_3C;
    #2;
    checks++; if ({vc_resp_valid, l1_resp_valid} !== 2'b10) $display("FAIL vcpri_resp vc/l1 got %b want 10", {vc_resp_valid, l1_resp_valid}); else passes++;
    checks++; if (l1_resp_rdata !== 128'd0) $display("FAIL vcpri_l1_rdata got %h want 0", l1_resp_rdata); else passes++;
    tick();
    mem_resp_valid = 0; vc_req_valid = 0;
    tick(); #2;
    checks++; if (busy !== 1'b0) $display("FAIL vcpri_idle_busy got %b want 0", busy); else passes++;
    tick(); #2;
    checks++; if ({busy, owner} !== 2'b10) $display("FAIL vcpri_l1_grant b/o got %b want 10", {busy, owner}); else passes++;
    checks++; if (mem_req_addr !== 32'h0000_2000) $display("FAIL vcpri_l1_addr got %h want 00002000", mem_req_addr); else passes++;
    mem_resp_valid = 1; mem_resp_rdata = DATA_3C;
    #2;
    checks++; if (l1_resp_rdata !== DATA_3C) $display("FAIL vcpri_l1_rdata2 got %h want %h", l1_resp_rdata, DATA_3C); else passes++;
    tick();
    mem_resp_valid = 0; l1_req_valid = 0;
    tick();
    $display("vc_priority: vc addr=%h then l1 addr=%h", 32'h0123_4560, 32'h0000_2000);
  endtask

  task automatic test_starvation();
    logic [6:0] want_owner;
    int vc_left;
    want_owner = 7'b1101111; // bit i = expected owner of grant i (VC x4, L1, VC x2)
    vc_left = 6;
    l1_req_valid = 1; l1_req_rw = 0; l1_req_addr = 32'h0000_3000;
    vc_req_valid = 1; vc_req_write = 1; vc_req_tag = 27'h0000ABC; vc_req_wdata = WDATA_V;
    for (int i = 0; i < 7; i++) begin
      tick();
      mem_resp_valid = 1; mem_resp_rdata = DATA_A5;
      #2;
      checks++; if (owner !== want_owner[i]) $display("FAIL starve_owner_%0d got %b want %b", i, owner, want_owner[i]); else passes++;
      checks++; if (vc_resp_valid !== want_owner[i]) $display("FAIL starve_vc_resp_%0d got %b want %b", i, vc_resp_valid, want_owner[i]); else passes++;
      $display("starvation: grant %0d owner=%b", i, owner);
      tick();
      mem_resp_valid = 0;
      if (want_owner[i]) begin
        vc_left--;
        if (vc_left == 0) vc_req_valid = 0;
      end else begin
        l1_req_valid = 0;
      end
      tick();
    end
    #2;
    checks++; if (busy !== 1'b0) $display("FAIL starve_final_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_timeout();
    int waited;
    l1_req_valid = 1; l1_req_rw = 0; l1_req_addr = 32'h0000_4000;
    mem_resp_rdata = DATA_A5;
    tick(); #2;
    checks++; if ({busy, timeout_err} !== 2'b10) $display("FAIL tmo_start b/err got %b want 10", {busy, timeout_err}); else passes++;
    waited = 0;
    while (l1_resp_valid !== 1'b1 && waited < 20) begin
      waited++;
      tick(); #2;
    end
    checks++; if (waited !== 8) $display("FAIL tmo_wait_cycles got %0d want 8", waited); else passes++;
    checks++; if ({l1_resp_valid, busy} !== 2'b11) $display("FAIL tmo_pulse resp/busy got %b want 11", {l1_resp_valid, busy}); else passes++;
    checks++; if (l1_resp_rdata !== 128'd0) $display("FAIL tmo_rdata got %h want 0", l1_resp_rdata); else passes++;
    tick(); #2;
    checks++; if ({timeout_err, busy, l1_resp_valid} !== 3'b100) $display("FAIL tmo_drain err/b/resp got %b want 100", {timeout_err, busy, l1_resp_valid}); else passes++;
    l1_req_valid = 0;
    vc_req_valid = 1; vc_req_write = 1; vc_req_tag = 27'h0000001; vc_req_wdata = WDATA_V;
    tick(); tick(); #2;
    checks++; if ({busy, owner, mem_req_addr} !== {2'b11, 32'h0000_0010}) $display("FAIL tmo_next_grant got %b/%b/%h want 1/1/00000010", busy, owner, mem_req_addr); else passes++;
    mem_resp_valid = 1;
    #2;
    checks++; if ({vc_resp_valid, timeout_err} !== 2'b11) $display("FAIL tmo_sticky vc_resp/err got %b want 11", {vc_resp_valid, timeout_err}); else passes++;
    tick();
    mem_resp_valid = 0; vc_req_valid = 0;
    tick();
    $display("timeout: fired after %0d busy cycles, err=%b", waited, timeout_err);
  endtask

  task automatic test_reset_mid_busy();
    l1_req_valid = 1; l1_req_rw = 1; l1_req_addr = 32'h0000_5000; l1_req_wdata = WDATA_L;
    tick(); #2;
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy); else passes++;
    rst_n = 0; mem_resp_valid = 1;
    #1;
    checks++; if ({busy, mem_req_valid, owner, timeout_err} !== 4'b0000) $display("FAIL rstmid_async b/v/o/err got %b want 0000", {busy, mem_req_valid, owner, timeout_err}); else passes++;
    checks++; if ({l1_resp_valid, vc_resp_valid} !== 2'b00) $display("FAIL rstmid_no_resp got %b want 00", {l1_resp_valid, vc_resp_valid}); else passes++;
    checks++; if (mem_req_addr !== 32'd0) $display("FAIL rstmid_addr got %h want 0", mem_req_addr); else passes++;
    tick();
    rst_n = 1; mem_resp_valid = 0;
    tick(); #2;
    checks++; if ({busy, owner, mem_req_rw} !== 3'b101) $display("FAIL rstmid_regrant b/o/rw got %b want 101", {busy, owner, mem_req_rw}); else passes++;
    checks++; if ({mem_req_addr, mem_req_wdata} !== {32'h0000_5000, WDATA_L}) $display("FAIL rstmid_regrant_data got %h/%h", mem_req_addr, mem_req_wdata); else passes++;
    mem_resp_valid = 1; mem_resp_rdata = DATA_3C;
    #2;
    checks++; if ({l1_resp_valid, l1_resp_rdata} !== {1'b1, 128'd0}) $display("FAIL rstmid_wr_resp got %b/%h want 1/0", l1_resp_valid, l1_resp_rdata); else passes++;
    tick();
    mem_resp_valid = 0; l1_req_valid = 0;
    tick();
    $display("reset_mid_busy: regranted addr=%h", 32'h0000_5000);
  endtask

  task automatic test_spurious_resp();
    mem_resp_valid = 1; mem_resp_rdata = DATA_A5;
    #2;
    checks++; if ({l1_resp_valid, vc_resp_valid} !== 2'b00) $display("FAIL spur_resp got %b want 00", {l1_resp_valid, vc_resp_valid}); else passes++;
    checks++; if (l1_resp_rdata !== 128'd0) $display("FAIL spur_rdata got %h want 0", l1_resp_rdata); else passes++;
    tick(); #2;
    checks++; if ({busy, mem_req_valid, l1_resp_valid, vc_resp_valid} !== 4'b0000) $display("FAIL spur_state got %b want 0000", {busy, mem_req_valid, l1_resp_valid, vc_resp_valid}); else passes++;
    mem_resp_valid = 0;
    tick();
    $display("spurious_resp: ignored in idle");
  endtask

  initial begin
    test_reset();
    test_l1_read();
    test_vc_priority();
    test_starvation();
    test_timeout();
    test_reset_mid_busy();
    test_spurious_resp();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sequences the single shared line-memory port between the L1 cache (read refills and write-backs) and the victim cache (dirty-line write-backs).
- Replaces the combinational VC-priority mux. Adds a registered grant held for the whole transaction and routes the response back to the owner.
- Adds a starvation guard for L1 and a per-transaction timeout.
- Sits between the L1/VC memory ports and the external memory interface in the top level.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_BYTES, 16, cache line size in bytes; OFFSET = log2(LINE_BYTES).
- VICTIM_TAG_WIDTH, 27, VC line tag width; VICTIM_TAG_WIDTH+OFFSET <= ADDR_WIDTH.
- MAX_VC_STREAK, 4, consecutive VC grants allowed while L1 waits.
- TIMEOUT_CYCLES, 255, max cycles a transaction may wait for mem_resp_valid; counter width = clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- l1_req_valid  in  1  L1 request, held until l1_resp_valid
- l1_req_rw  in  1  1=write-back, 0=refill read
- l1_req_addr  in  ADDR_WIDTH  line address
- l1_req_wdata  in  LINE_BYTES*8  write line
- l1_resp_valid  out  1  one-cycle response to L1
- l1_resp_rdata  out  LINE_BYTES*8  refill data
- vc_req_valid  in  1  VC request, held until vc_resp_valid
- vc_req_write  in  1  1=write
- vc_req_tag  in  VICTIM_TAG_WIDTH  line tag
- vc_req_wdata  in  LINE_BYTES*8  write line
- vc_resp_valid  out  1  one-cycle completion to VC
- mem_req_valid  out  1  memory request, held until mem_resp_valid
- mem_req_rw  out  1  1=write
- mem_req_addr  out  ADDR_WIDTH  byte address
- mem_req_wdata  out  LINE_BYTES*8  write line
- mem_resp_valid  in  1  memory completion pulse
- mem_resp_rdata  in  LINE_BYTES*8  read line
- owner  out  1  0=L1, 1=VC; valid while busy
- busy  out  1  transaction in flight
- timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: mem_req_valid, l1_resp_valid, vc_resp_valid, busy, owner, timeout_err.
  - mem_req_addr/wdata/rw = 0; streak and timeout counters = 0.
  - A reset asserted mid-transaction abandons it with no response pulse.
- FSM states IDLE -> BUSY -> DRAIN -> IDLE.
- IDLE:
  - If any request is valid, grant at the clock edge and go to BUSY.
  - Capture the winner's rw/addr/wdata into output registers; set owner; set mem_req_valid=1 and busy=1 the next cycle.
  - Zero-cycle arbitration, one-cycle issue latency.
- Arbitration, VC priority:
  - Grant VC if vc_req_valid and not (l1_req_valid and streak==MAX_VC_STREAK).
  - Otherwise grant L1 if l1_req_valid.
- Streak counter:
  - Increments, saturating at MAX_VC_STREAK, on a VC grant while l1_req_valid=1.
  - Clears on an L1 grant.
  - Unchanged on a VC grant with L1 idle.
- VC address: mem_req_addr = zero-extend({vc_req_tag, OFFSET'b0}).
- L1 address: passed unchanged.
- BUSY:
  - Outputs held stable.
  - Timeout counter increments each cycle.
  - On mem_resp_valid, in the same cycle (combinational): assert the owner's resp_valid; l1_resp_rdata = mem_resp_rdata, and only for an L1 read. Then go to DRAIN; mem_req_valid drops next cycle.
  - If the counter reaches TIMEOUT_CYCLES without a response: set timeout_err, pulse the owner's resp_valid (rdata=0), go to DRAIN.
- DRAIN:
  - One cycle; busy=0, mem_req_valid=0.
  - Requests are ignored so a requester's stale valid is not regranted. Then go to IDLE.
- mem_resp_valid in IDLE or DRAIN is ignored.
- l1_resp_rdata is 0 whenever l1_resp_valid=0.
- A non-owner request arriving during BUSY waits; it is evaluated at the next IDLE.
- Back-to-back transactions: minimum 3 cycles per transaction (grant, respond, drain).

Test Plan:
- L1-only read, addr 0x0000_1230, memory responds 2 cycles after mem_req_valid with data 0xA5..A5:
  - mem_req_addr=0x0000_1230, rw=0.
  - l1_resp_valid for exactly one cycle, l1_resp_rdata=0xA5..A5.
  - vc_resp_valid stays 0; busy is 0 in DRAIN.
- VC write, tag 0x0123456, same cycle as L1 read request:
  - VC is granted first; mem_req_addr=0x0123_4560, rw=1, wdata passed through.
  - vc_resp_valid pulses; L1 is granted after DRAIN.
- Starvation: L1 held valid, VC issues 6 back-to-back writes with MAX_VC_STREAK=4:
  - Grant order VC, VC, VC, VC, L1, VC, VC.
- Timeout, TIMEOUT_CYCLES=8, memory never responds to an L1 read:
  - After 8 BUSY cycles: timeout_err=1 (sticky), l1_resp_valid pulses with rdata=0, FSM returns to IDLE and accepts the next request.
- rst_n pulsed low mid-BUSY:
  - All outputs 0 immediately (async); no resp pulse.
  - After release, the held request is regranted normally.
- Spurious mem_resp_valid in IDLE:
  - No resp pulses, no state change.
